// File: rtl/aes_i2c_pkg.sv
// Shared definitions for the I2C-to-AES frame sequencer: state encoding, frame layout, command bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Frame layout: [263:256]=cmd, [255:128]=key, [127:0]=block
  localparam int FRAME_BYTES  = 33;
  localparam int FRAME_W      = FRAME_BYTES * 8;
  localparam int CMD_MSB      = 263;
  localparam int KEY_MSB      = 255;
  localparam int BLK_MSB      = 127;

  // Command byte bit indices; bits [7:2] are reserved and must be zero
  localparam int CMD_DECRYPT  = 0;
  localparam int CMD_KEEP_KEY = 1;

endpackage

// File: rtl/aes_frame_ctrl_if.sv
// Bundles the frame input, AES core link, result handshake and error flags of aes_frame_ctrl.
// Latency: n/a (wires only). err_tmo exists only when AES_FRAME_CTRL_TIMEOUT_EN is defined.
// Backpressure: result_valid/result_ack handshake toward the consumer; the frame side cannot be stalled.
interface aes_frame_ctrl_if;
  import aes_i2c_pkg::*;

  logic [FRAME_W-1:0] frame_data;
  logic               frame_done;
  logic [127:0]       aes_key;
  logic [127:0]       aes_block;
  logic               aes_decrypt;
  logic               aes_start;
  logic               aes_done;
  logic [127:0]       aes_result;
  logic [127:0]       result;
  logic               result_valid;
  logic               result_ack;
  logic               busy;
  logic               err_cmd;
  logic               err_ovr;
  logic               err_clr;
`ifdef AES_FRAME_CTRL_TIMEOUT_EN
  logic               err_tmo;
`endif

  // Controller view
  modport slave (
    input  frame_data, frame_done, aes_done, aes_result, result_ack, err_clr,
    output aes_key, aes_block, aes_decrypt, aes_start, result, result_valid,
           busy, err_cmd, err_ovr
`ifdef AES_FRAME_CTRL_TIMEOUT_EN
    , output err_tmo
`endif
  );

  // Environment view (I2C slave, AES core and result consumer)
  modport master (
    output frame_data, frame_done, aes_done, aes_result, result_ack, err_clr,
    input  aes_key, aes_block, aes_decrypt, aes_start, result, result_valid,
           busy, err_cmd, err_ovr
`ifdef AES_FRAME_CTRL_TIMEOUT_EN
    , input err_tmo
`endif
  );

endinterface

// File: rtl/aes_frame_ctrl.sv
// Sequences the AES128 core from 33-byte I2C frames: decode/validate cmd, load key/block, start, hold result.
// Latency: frame edge in cycle N -> aes_start in N+2; result_valid the cycle after aes_done.
// Backpressure: result held until result_ack; frames arriving while busy are dropped and flag err_ovr.
// Optional: AES_FRAME_CTRL_TIMEOUT_EN adds a WAIT timeout (TIMEOUT_CYCLES) and the sticky err_tmo flag.
module aes_frame_ctrl
  import aes_i2c_pkg::*;
`ifdef AES_FRAME_CTRL_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
)
`endif
(
  input  logic            clk,
  input  logic            reset_n,
  aes_frame_ctrl_if.slave bus
);

  state_e       state_q, state_d;
  logic         frame_done_q;
  logic         frame_evt;
  logic [7:0]   cmd_q;
  logic [127:0] key_q;
  logic [127:0] blk_q;
  logic         cmd_bad;
  logic         key_loaded_q;
  logic [127:0] aes_key_q;
  logic [127:0] aes_block_q;
  logic         aes_decrypt_q;
  logic [127:0] result_q;
  logic         result_valid_q;
  logic         err_cmd_q;
  logic         err_ovr_q;
  logic         tmo_hit;

  // frame_done is a level; one event per frame on its rising edge
  assign frame_evt = bus.frame_done & ~frame_done_q;
  assign cmd_bad   = (|cmd_q[7:2]) | (cmd_q[CMD_KEEP_KEY] & ~key_loaded_q);

  // Edge-detector history, sampled every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_done_q <= 1'b0;
    else          frame_done_q <= bus.frame_done;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_evt) state_d = ST_CHECK;
      ST_CHECK: state_d = cmd_bad ? ST_IDLE : ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (bus.aes_done || tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: start strobe and busy derived from state alone
  always_comb begin
    bus.aes_start = (state_q == ST_START);
    bus.busy      = (state_q != ST_IDLE);
  end

  // Capture the frame only when it is accepted in IDLE; overrun frames never touch these
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      key_q <= '0;
      blk_q <= '0;
    end else if (state_q == ST_IDLE && frame_evt) begin
      cmd_q <= bus.frame_data[CMD_MSB -: 8];
      key_q <= bus.frame_data[KEY_MSB -: 128];
      blk_q <= bus.frame_data[BLK_MSB -: 128];
    end
  end

  // Core operands change only when a valid command passes CHECK, then stay stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aes_key_q     <= '0;
      aes_block_q   <= '0;
      aes_decrypt_q <= 1'b0;
      key_loaded_q  <= 1'b0;
    end else if (state_q == ST_CHECK && !cmd_bad) begin
      if (!cmd_q[CMD_KEEP_KEY]) aes_key_q <= key_q;
      aes_block_q   <= blk_q;
      aes_decrypt_q <= cmd_q[CMD_DECRYPT];
      key_loaded_q  <= 1'b1;
    end
  end

  // Result holding: a fresh aes_done beats a same-cycle ack; a new accepted frame invalidates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (state_q == ST_WAIT && bus.aes_done) begin
      result_q       <= bus.aes_result;
      result_valid_q <= 1'b1;
    end else if (state_q == ST_CHECK && !cmd_bad) begin
      result_valid_q <= 1'b0;
    end else if (bus.result_ack) begin
      result_valid_q <= 1'b0;
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cmd_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      if (state_q == ST_CHECK && cmd_bad) err_cmd_q <= 1'b1;
      else if (bus.err_clr)               err_cmd_q <= 1'b0;
      if (state_q != ST_IDLE && frame_evt) err_ovr_q <= 1'b1;
      else if (bus.err_clr)                err_ovr_q <= 1'b0;
    end
  end

`ifdef AES_FRAME_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_tmo_q;

  // Last allowed WAIT cycle is count TIMEOUT_CYCLES-1; leaving then gives TIMEOUT_CYCLES WAIT cycles
  always_comb begin
    tmo_hit = (state_q == ST_WAIT) && !bus.aes_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
  end

  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tmo_hit)          err_tmo_q <= 1'b1;
      else if (bus.err_clr) err_tmo_q <= 1'b0;
    end
  end

  assign bus.err_tmo = err_tmo_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus.aes_key      = aes_key_q;
  assign bus.aes_block    = aes_block_q;
  assign bus.aes_decrypt  = aes_decrypt_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err_cmd      = err_cmd_q;
  assign bus.err_ovr      = err_ovr_q;

endmodule
